// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode constants,
// alu_control class codes, datapath mux encodings and the control state enum.
package mips_pkg;

   // Instruction opcodes, IR[31:26]
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   // Class codes handed to alu_control
   localparam logic [2:0] ALUC_R   = 3'b000;
   localparam logic [2:0] ALUC_ADD = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b011;
   localparam logic [2:0] ALUC_OR  = 3'b100;

   // ALU B operand select
   localparam logic [1:0] ALUSRCB_RT   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
   localparam logic [1:0] ALUSRCB_SEXT = 2'b10;
   localparam logic [1:0] ALUSRCB_ZEXT = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_JUMP = 2'b01;

   // Control states; the code is visible on o_state for debug
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_ADD = 4'd3,
      S_EXEC_AND = 4'd4,
      S_EXEC_OR  = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_WB_R     = 4'd8,
      S_WB_I     = 4'd9,
      S_WB_MEM   = 4'd10,
      S_JUMP     = 4'd11,
      S_ERROR    = 4'd12
   } state_e;

endpackage

// File: rtl/control_fsm_10.sv
// Multicycle MIPS main control unit (Moore FSM).
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives every datapath select and write
// enable, waits on the memory ready handshake and traps illegal opcodes and
// memory timeouts into an absorbing ERROR state.
// Ports:
//   i_clk, i_rst       clock (rising edge), async active-high reset
//   i_opcode[5:0]      IR[31:26], sampled in DECODE only
//   i_mem_ready        memory completes the current read/write this cycle
//   o_pc_we, o_ir_we   PC / IR write enables
//   o_iord             memory address select (0=PC, 1=ALUOut)
//   o_mem_rd, o_mem_wr memory read / write request
//   o_reg_we, o_regdst, o_memtoreg   register file write controls
//   o_alusrc_a, o_alusrc_b[1:0]      ALU operand selects
//   o_pcsrc[1:0]       PC source select
//   o_aluc[2:0]        class code to alu_control
//   o_error            sticky error flag (set while in ERROR)
//   o_state[3:0]       current state code
module control_fsm_10
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output logic       o_pc_we,
   output logic       o_ir_we,
   output logic       o_iord,
   output logic       o_mem_rd,
   output logic       o_mem_wr,
   output logic       o_reg_we,
   output logic       o_regdst,
   output logic       o_memtoreg,
   output logic       o_alusrc_a,
   output logic [1:0] o_alusrc_b,
   output logic [1:0] o_pcsrc,
   output logic [2:0] o_aluc,
   output logic       o_error,
   output logic [3:0] o_state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

   state_e             state_r;
   state_e             next_state_s;
   logic [5:0]         opcode_r;
   logic [CNT_W-1:0]   tmo_cnt_r;
   logic               wait_state_s;
   logic               tmo_hit_s;

   // Memory-handshake states and the "last allowed cycle without ready" condition
   always_comb begin
      wait_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
      tmo_hit_s    = wait_state_s && !i_mem_ready &&
                     (tmo_cnt_r == CNT_W'(MEM_TIMEOUT - 1));
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Opcode captured in DECODE so later states never look at i_opcode again
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         opcode_r <= 6'b000000;
      end else if (state_r == S_DECODE) begin
         opcode_r <= i_opcode;
      end else begin
         opcode_r <= opcode_r;
      end
   end

   // Timeout counter: any state change clears it, so each wait state starts at 0
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt_r <= '0;
      end else if (next_state_s != state_r) begin
         tmo_cnt_r <= '0;
      end else if (wait_state_s && !i_mem_ready) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (i_mem_ready) begin
               next_state_s = S_DECODE;
            end else if (tmo_hit_s) begin
               next_state_s = S_ERROR;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (i_opcode)
               OP_R:    next_state_s = S_EXEC_R;
               OP_LW:   next_state_s = S_EXEC_ADD;
               OP_SW:   next_state_s = S_EXEC_ADD;
               OP_ADDI: next_state_s = S_EXEC_ADD;
               OP_ANDI: next_state_s = S_EXEC_AND;
               OP_ORI:  next_state_s = S_EXEC_OR;
               OP_J:    next_state_s = S_JUMP;
               default: next_state_s = S_ERROR;
            endcase
         end
         S_EXEC_R:   next_state_s = S_WB_R;
         S_EXEC_ADD: begin
            case (opcode_r)
               OP_LW:   next_state_s = S_MEM_RD;
               OP_SW:   next_state_s = S_MEM_WR;
               OP_ADDI: next_state_s = S_WB_I;
               default: next_state_s = S_ERROR;
            endcase
         end
         S_EXEC_AND: next_state_s = S_WB_I;
         S_EXEC_OR:  next_state_s = S_WB_I;
         S_MEM_RD: begin
            if (i_mem_ready) begin
               next_state_s = S_WB_MEM;
            end else if (tmo_hit_s) begin
               next_state_s = S_ERROR;
            end else begin
               next_state_s = S_MEM_RD;
            end
         end
         S_MEM_WR: begin
            if (i_mem_ready) begin
               next_state_s = S_FETCH;
            end else if (tmo_hit_s) begin
               next_state_s = S_ERROR;
            end else begin
               next_state_s = S_MEM_WR;
            end
         end
         S_WB_R:   next_state_s = S_FETCH;
         S_WB_I:   next_state_s = S_FETCH;
         S_WB_MEM: next_state_s = S_FETCH;
         S_JUMP:   next_state_s = S_FETCH;
         S_ERROR:  next_state_s = S_ERROR;
         // Unused encodings are treated as corruption and trapped
         default:  next_state_s = S_ERROR;
      endcase
   end

   // Output decode from the state register; FETCH write enables also need ready
   always_comb begin
      o_pc_we    = 1'b0;
      o_ir_we    = 1'b0;
      o_iord     = 1'b0;
      o_mem_rd   = 1'b0;
      o_mem_wr   = 1'b0;
      o_reg_we   = 1'b0;
      o_regdst   = 1'b0;
      o_memtoreg = 1'b0;
      o_alusrc_a = 1'b0;
      o_alusrc_b = ALUSRCB_RT;
      o_pcsrc    = PCSRC_ALU;
      o_aluc     = ALUC_ADD;
      o_error    = 1'b0;
      case (state_r)
         S_FETCH: begin
            o_mem_rd   = 1'b1;
            o_alusrc_b = ALUSRCB_FOUR;
            o_pc_we    = i_mem_ready;
            o_ir_we    = i_mem_ready;
         end
         S_DECODE: begin
            o_aluc = ALUC_ADD;
         end
         S_EXEC_R: begin
            o_alusrc_a = 1'b1;
            o_alusrc_b = ALUSRCB_RT;
            o_aluc     = ALUC_R;
         end
         S_EXEC_ADD: begin
            o_alusrc_a = 1'b1;
            o_alusrc_b = ALUSRCB_SEXT;
            o_aluc     = ALUC_ADD;
         end
         S_EXEC_AND: begin
            o_alusrc_a = 1'b1;
            o_alusrc_b = ALUSRCB_ZEXT;
            o_aluc     = ALUC_AND;
         end
         S_EXEC_OR: begin
            o_alusrc_a = 1'b1;
            o_alusrc_b = ALUSRCB_ZEXT;
            o_aluc     = ALUC_OR;
         end
         S_MEM_RD: begin
            o_mem_rd = 1'b1;
            o_iord   = 1'b1;
         end
         S_MEM_WR: begin
            o_mem_wr = 1'b1;
            o_iord   = 1'b1;
         end
         S_WB_R: begin
            o_reg_we = 1'b1;
            o_regdst = 1'b1;
         end
         S_WB_I: begin
            o_reg_we = 1'b1;
         end
         S_WB_MEM: begin
            o_reg_we   = 1'b1;
            o_memtoreg = 1'b1;
         end
         S_JUMP: begin
            o_pc_we = 1'b1;
            o_pcsrc = PCSRC_JUMP;
         end
         S_ERROR: begin
            o_error = 1'b1;
         end
         default: begin
            o_error = 1'b1;
         end
      endcase
   end

   assign o_state = state_r;

endmodule

// File: tb/tb_control_fsm_10.sv
// Directed bench for control_fsm_10. Expected output vectors are built from
// the bench's own per-state table, queued when a step is driven and popped
// when the DUT outputs are sampled on the falling edge.
module tb_control_fsm_10;
   import mips_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [5:0] i_opcode = 6'b111111;
   logic       i_mem_ready = 1'b0;

   // default-timeout instance
   logic       pc_we_a, ir_we_a, iord_a, mem_rd_a, mem_wr_a, reg_we_a, regdst_a, memtoreg_a;
   logic       alusrc_a_a, error_a;
   logic [1:0] alusrc_b_a, pcsrc_a;
   logic [2:0] aluc_a;
   logic [3:0] state_a;
   // MEM_TIMEOUT=4 instance
   logic       pc_we_b, ir_we_b, iord_b, mem_rd_b, mem_wr_b, reg_we_b, regdst_b, memtoreg_b;
   logic       alusrc_a_b, error_b;
   logic [1:0] alusrc_b_b, pcsrc_b;
   logic [2:0] aluc_b;
   logic [3:0] state_b;

   int checks = 0;
   int failures = 0;
   logic [20:0] exp_q[$];

   control_fsm_10 dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
      .o_pc_we(pc_we_a), .o_ir_we(ir_we_a), .o_iord(iord_a), .o_mem_rd(mem_rd_a),
      .o_mem_wr(mem_wr_a), .o_reg_we(reg_we_a), .o_regdst(regdst_a), .o_memtoreg(memtoreg_a),
      .o_alusrc_a(alusrc_a_a), .o_alusrc_b(alusrc_b_a), .o_pcsrc(pcsrc_a), .o_aluc(aluc_a),
      .o_error(error_a), .o_state(state_a)
   );

   control_fsm_10 #(.MEM_TIMEOUT(4)) dut4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
      .o_pc_we(pc_we_b), .o_ir_we(ir_we_b), .o_iord(iord_b), .o_mem_rd(mem_rd_b),
      .o_mem_wr(mem_wr_b), .o_reg_we(reg_we_b), .o_regdst(regdst_b), .o_memtoreg(memtoreg_b),
      .o_alusrc_a(alusrc_a_b), .o_alusrc_b(alusrc_b_b), .o_pcsrc(pcsrc_b), .o_aluc(aluc_b),
      .o_error(error_b), .o_state(state_b)
   );

   always #5 i_clk = ~i_clk;

   // Vector layout: {state, pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, regdst,
   //                 memtoreg, alusrc_a, alusrc_b[1:0], pcsrc[1:0], aluc[2:0], error}
   function automatic logic [20:0] expect_vec(input state_e st, input logic rdy);
      logic pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, regdst, memtoreg, alu_a, err;
      logic [1:0] alu_b, pcsrc;
      logic [2:0] aluc;
      pc_we = 1'b0; ir_we = 1'b0; iord = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      reg_we = 1'b0; regdst = 1'b0; memtoreg = 1'b0; alu_a = 1'b0; err = 1'b0;
      alu_b = 2'b00; pcsrc = 2'b00; aluc = 3'b001;
      case (st)
         S_FETCH:    begin mem_rd = 1'b1; alu_b = 2'b01; pc_we = rdy; ir_we = rdy; end
         S_EXEC_R:   begin alu_a = 1'b1; alu_b = 2'b00; aluc = 3'b000; end
         S_EXEC_ADD: begin alu_a = 1'b1; alu_b = 2'b10; aluc = 3'b001; end
         S_EXEC_AND: begin alu_a = 1'b1; alu_b = 2'b11; aluc = 3'b011; end
         S_EXEC_OR:  begin alu_a = 1'b1; alu_b = 2'b11; aluc = 3'b100; end
         S_MEM_RD:   begin mem_rd = 1'b1; iord = 1'b1; end
         S_MEM_WR:   begin mem_wr = 1'b1; iord = 1'b1; end
         S_WB_R:     begin reg_we = 1'b1; regdst = 1'b1; end
         S_WB_I:     begin reg_we = 1'b1; end
         S_WB_MEM:   begin reg_we = 1'b1; memtoreg = 1'b1; end
         S_JUMP:     begin pc_we = 1'b1; pcsrc = 2'b01; end
         S_ERROR:    begin err = 1'b1; end
         default:    begin end
      endcase
      return {st, pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, regdst, memtoreg,
              alu_a, alu_b, pcsrc, aluc, err};
   endfunction

   function automatic logic [20:0] observed(input bit sel4);
      if (sel4)
         return {state_b, pc_we_b, ir_we_b, iord_b, mem_rd_b, mem_wr_b, reg_we_b, regdst_b,
                 memtoreg_b, alusrc_a_b, alusrc_b_b, pcsrc_b, aluc_b, error_b};
      else
         return {state_a, pc_we_a, ir_we_a, iord_a, mem_rd_a, mem_wr_a, reg_we_a, regdst_a,
                 memtoreg_a, alusrc_a_a, alusrc_b_a, pcsrc_a, aluc_a, error_a};
   endfunction

   // Pop the oldest expectation and compare it with the selected instance now
   task automatic compare(input bit sel4, input string tag);
      logic [20:0] e;
      logic [20:0] o;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         o = observed(sel4);
         assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
         end
      end
   endtask

   // Drive one cycle's inputs, check on the falling edge, advance past the rising edge
   task automatic step(input bit sel4, input logic rdy, input logic [5:0] op,
                       input state_e st, input string tag);
      i_mem_ready = rdy;
      i_opcode    = op;
      exp_q.push_back(expect_vec(st, rdy));
      @(negedge i_clk);
      compare(sel4, tag);
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_mem_ready = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   // Memory read and write are never requested together by either instance
   always @(negedge i_clk) begin
      if (!i_rst) begin
         checks++;
         assert (!(mem_rd_a && mem_wr_a) && !(mem_rd_b && mem_wr_b)) else begin
            failures++;
            $error("FAIL rd_wr_excl observed=%b%b%b%b expected=no rd&wr pair",
                   mem_rd_a, mem_wr_a, mem_rd_b, mem_wr_b);
         end
      end
   end

   localparam logic [5:0] JUNK = 6'b111111;

   initial begin
      // Reset state, held reset
      @(posedge i_clk);
      #1;
      exp_q.push_back(expect_vec(S_FETCH, 1'b0));
      compare(1'b0, "reset_state");
      do_reset();

      // R-type with a one-cycle FETCH wait first
      step(1'b0, 1'b0, JUNK, S_FETCH,  "r_fetch_wait");
      step(1'b0, 1'b1, JUNK, S_FETCH,  "r_fetch");
      step(1'b0, 1'b0, OP_R, S_DECODE, "r_decode");
      step(1'b0, 1'b0, JUNK, S_EXEC_R, "r_exec");
      step(1'b0, 1'b0, JUNK, S_WB_R,   "r_wb");

      // lw with three not-ready cycles in MEM_RD (8 cycles total)
      step(1'b0, 1'b1, JUNK,  S_FETCH,    "lw_fetch");
      step(1'b0, 1'b0, OP_LW, S_DECODE,   "lw_decode");
      step(1'b0, 1'b1, JUNK,  S_EXEC_ADD, "lw_exec");
      step(1'b0, 1'b0, JUNK,  S_MEM_RD,   "lw_mem0");
      step(1'b0, 1'b0, JUNK,  S_MEM_RD,   "lw_mem1");
      step(1'b0, 1'b0, JUNK,  S_MEM_RD,   "lw_mem2");
      step(1'b0, 1'b1, JUNK,  S_MEM_RD,   "lw_mem3");
      step(1'b0, 1'b0, JUNK,  S_WB_MEM,   "lw_wb");

      // sw, ready immediately
      step(1'b0, 1'b1, JUNK,  S_FETCH,    "sw_fetch");
      step(1'b0, 1'b0, OP_SW, S_DECODE,   "sw_decode");
      step(1'b0, 1'b0, JUNK,  S_EXEC_ADD, "sw_exec");
      step(1'b0, 1'b1, JUNK,  S_MEM_WR,   "sw_mem");

      // addi
      step(1'b0, 1'b1, JUNK,    S_FETCH,    "addi_fetch");
      step(1'b0, 1'b0, OP_ADDI, S_DECODE,   "addi_decode");
      step(1'b0, 1'b0, JUNK,    S_EXEC_ADD, "addi_exec");
      step(1'b0, 1'b0, JUNK,    S_WB_I,     "addi_wb");

      // ori and andi
      step(1'b0, 1'b1, JUNK,   S_FETCH,    "ori_fetch");
      step(1'b0, 1'b0, OP_ORI, S_DECODE,   "ori_decode");
      step(1'b0, 1'b0, JUNK,   S_EXEC_OR,  "ori_exec");
      step(1'b0, 1'b0, JUNK,   S_WB_I,     "ori_wb");
      step(1'b0, 1'b1, JUNK,    S_FETCH,    "andi_fetch");
      step(1'b0, 1'b0, OP_ANDI, S_DECODE,   "andi_decode");
      step(1'b0, 1'b0, JUNK,    S_EXEC_AND, "andi_exec");
      step(1'b0, 1'b0, JUNK,    S_WB_I,     "andi_wb");

      // jump
      step(1'b0, 1'b1, JUNK, S_FETCH,  "j_fetch");
      step(1'b0, 1'b0, OP_J, S_DECODE, "j_decode");
      step(1'b0, 1'b0, JUNK, S_JUMP,   "j_jump");
      step(1'b0, 1'b1, JUNK, S_FETCH,  "j_next_fetch");

      // Reset mid-EXEC_R takes effect with no clock edge
      step(1'b0, 1'b0, OP_R, S_DECODE, "rst_decode");
      i_mem_ready = 1'b0;
      exp_q.push_back(expect_vec(S_EXEC_R, 1'b0));
      @(negedge i_clk);
      compare(1'b0, "rst_pre_exec");
      i_rst = 1'b1;
      #1;
      exp_q.push_back(expect_vec(S_FETCH, 1'b0));
      compare(1'b0, "rst_async_fetch");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Illegal opcode traps and stays trapped
      step(1'b0, 1'b1, JUNK, S_FETCH,  "ill_fetch");
      step(1'b0, 1'b1, JUNK, S_DECODE, "ill_decode");
      for (int k = 0; k < 20; k++)
         step(1'b0, k[0], OP_J, S_ERROR, "ill_error_hold");
      do_reset();

      // MEM_TIMEOUT=4: sw never ready -> ERROR after 4 MEM_WR cycles
      step(1'b1, 1'b1, JUNK,  S_FETCH,    "tmo_fetch");
      step(1'b1, 1'b0, OP_SW, S_DECODE,   "tmo_decode");
      step(1'b1, 1'b0, JUNK,  S_EXEC_ADD, "tmo_exec");
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, JUNK, S_MEM_WR, "tmo_memwr");
      step(1'b1, 1'b0, JUNK, S_ERROR, "tmo_error");
      do_reset();

      // MEM_TIMEOUT=4: ready on the 4th MEM_WR cycle still succeeds
      step(1'b1, 1'b1, JUNK,  S_FETCH,    "last_fetch");
      step(1'b1, 1'b0, OP_SW, S_DECODE,   "last_decode");
      step(1'b1, 1'b0, JUNK,  S_EXEC_ADD, "last_exec");
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b0, JUNK, S_MEM_WR, "last_memwr_wait");
      step(1'b1, 1'b1, JUNK, S_MEM_WR, "last_memwr_ready");

      // MEM_TIMEOUT=4: FETCH timeout
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, JUNK, S_FETCH, "fetch_tmo_wait");
      step(1'b1, 1'b1, JUNK, S_ERROR, "fetch_tmo_error");
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
